// File: rtl/conv2d_ctrl.sv
// rtl/conv2d_ctrl.sv - sequential single-MAC 2-D convolution controller
module conv2d_ctrl #(
    parameter int in_channels  = 1,
    parameter int out_channels = 1,
    parameter int kernel_rows  = 1,
    parameter int kernel_cols  = 1,
    parameter int stride_row   = 1,
    parameter int stride_col   = 1,
    parameter int pad_rows     = 0,
    parameter int pad_cols     = 0,
    parameter int rows         = 27,
    parameter int cols         = 27,
    parameter int data_size    = 8,
    localparam int out_rows = (rows + 2*pad_rows - kernel_rows)/stride_row + 1,
    localparam int out_cols = (cols + 2*pad_cols - kernel_cols)/stride_col + 1,
    localparam int n_taps   = in_channels*kernel_rows*kernel_cols,
    localparam int in_w     = (in_channels*rows*cols > 1) ? $clog2(in_channels*rows*cols) : 1,
    localparam int kern_w   = (out_channels*n_taps > 1) ? $clog2(out_channels*n_taps) : 1,
    localparam int bias_w   = (out_channels > 1) ? $clog2(out_channels) : 1,
    localparam int out_w    = (out_channels*out_rows*out_cols > 1) ?
                              $clog2(out_channels*out_rows*out_cols) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [in_w-1:0]      in_addr,
    input  logic [data_size-1:0] in_data,
    output logic [kern_w-1:0]    kern_addr,
    input  logic [data_size-1:0] kern_data,
    output logic [bias_w-1:0]    bias_addr,
    input  logic [data_size-1:0] bias_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [out_w-1:0]     out_addr,
    output logic [data_size-1:0] out_data
);

    localparam int ci_w  = (in_channels > 1) ? $clog2(in_channels) : 1;
    localparam int kr_w  = (kernel_rows > 1) ? $clog2(kernel_rows) : 1;
    localparam int kc_w  = (kernel_cols > 1) ? $clog2(kernel_cols) : 1;
    localparam int or_w  = (out_rows > 1) ? $clog2(out_rows) : 1;
    localparam int oc_w  = (out_cols > 1) ? $clog2(out_cols) : 1;
    localparam int acc_w = 2*data_size + $clog2(n_taps + 1);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, WRITE} state_t;

    state_t            state, state_n;
    logic [bias_w-1:0] co, co_n;
    logic [or_w-1:0]   orow, orow_n;
    logic [oc_w-1:0]   ocol, ocol_n;
    logic [ci_w-1:0]   ci, ci_n;
    logic [kr_w-1:0]   kr, kr_n;
    logic [kc_w-1:0]   kc, kc_n;
    logic              done_n;
    logic              tap_last, pix_last, cur_pad;
    logic [in_w-1:0]   in_addr_n;
    logic [kern_w-1:0] kern_addr_n;

    // Tap pipeline: stage-2 flags describe the tap whose data is arriving now
    logic                     d_valid, d_first, d_pad;
    logic signed [acc_w-1:0]  acc, acc_sum, tap_term, bias_term;
    logic signed [2*data_size-1:0] prod;

    function automatic logic tap_is_pad(input int orow_i, input int ocol_i,
                                        input int kr_i, input int kc_i);
        int r;
        int c;
        r = orow_i*stride_row + kr_i - pad_rows;
        c = ocol_i*stride_col + kc_i - pad_cols;
        return (r < 0) || (r >= rows) || (c < 0) || (c >= cols);
    endfunction

    function automatic int tap_in_addr(input int ci_i, input int orow_i, input int ocol_i,
                                       input int kr_i, input int kc_i);
        int r;
        int c;
        r = orow_i*stride_row + kr_i - pad_rows;
        c = ocol_i*stride_col + kc_i - pad_cols;
        if (tap_is_pad(orow_i, ocol_i, kr_i, kc_i)) return 0;
        return ci_i*rows*cols + r*cols + c;
    endfunction

    // Next state, loop counters and the addresses for the tap issued next cycle
    always_comb begin
        state_n  = state;
        co_n     = co;
        orow_n   = orow;
        ocol_n   = ocol;
        ci_n     = ci;
        kr_n     = kr;
        kc_n     = kc;
        done_n   = 1'b0;
        tap_last = (ci == ci_w'(in_channels-1)) && (kr == kr_w'(kernel_rows-1)) &&
                   (kc == kc_w'(kernel_cols-1));
        pix_last = (co == bias_w'(out_channels-1)) && (orow == or_w'(out_rows-1)) &&
                   (ocol == oc_w'(out_cols-1));
        case (state)
            IDLE: begin
                if (start) state_n = MAC;
            end
            MAC: begin
                if (tap_last) begin
                    state_n = DRAIN;
                    ci_n = '0;
                    kr_n = '0;
                    kc_n = '0;
                end else if (kc != kc_w'(kernel_cols-1)) begin
                    kc_n = kc + 1'b1;
                end else begin
                    kc_n = '0;
                    if (kr != kr_w'(kernel_rows-1)) begin
                        kr_n = kr + 1'b1;
                    end else begin
                        kr_n = '0;
                        ci_n = ci + 1'b1;
                    end
                end
            end
            DRAIN: state_n = WRITE;
            WRITE: begin
                if (out_ready) begin
                    if (pix_last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        co_n    = '0;
                        orow_n  = '0;
                        ocol_n  = '0;
                    end else begin
                        state_n = MAC;
                        if (ocol != oc_w'(out_cols-1)) begin
                            ocol_n = ocol + 1'b1;
                        end else begin
                            ocol_n = '0;
                            if (orow != or_w'(out_rows-1)) begin
                                orow_n = orow + 1'b1;
                            end else begin
                                orow_n = '0;
                                co_n   = co + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        in_addr_n   = in_w'(tap_in_addr(int'(ci_n), int'(orow_n), int'(ocol_n),
                                        int'(kr_n), int'(kc_n)));
        kern_addr_n = kern_w'(((int'(co_n)*in_channels + int'(ci_n))*kernel_rows +
                               int'(kr_n))*kernel_cols + int'(kc_n));
        cur_pad     = tap_is_pad(int'(orow), int'(ocol), int'(kr), int'(kc));
        out_addr    = out_w'(int'(co)*out_rows*out_cols + int'(orow)*out_cols + int'(ocol));
    end

    // State, counters, registered read addresses and the tap pipeline flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            co        <= '0;
            orow      <= '0;
            ocol      <= '0;
            ci        <= '0;
            kr        <= '0;
            kc        <= '0;
            in_addr   <= '0;
            kern_addr <= '0;
            done      <= 1'b0;
            d_valid   <= 1'b0;
            d_first   <= 1'b0;
            d_pad     <= 1'b0;
        end else begin
            state     <= state_n;
            co        <= co_n;
            orow      <= orow_n;
            ocol      <= ocol_n;
            ci        <= ci_n;
            kr        <= kr_n;
            kc        <= kc_n;
            in_addr   <= in_addr_n;
            kern_addr <= kern_addr_n;
            done      <= done_n;
            d_valid   <= (state == MAC);
            d_first   <= (ci == '0) && (kr == '0) && (kc == '0);
            d_pad     <= cur_pad;
        end
    end

    // Sign-extended product and bias; a padded tap contributes nothing
    always_comb begin
        prod      = $signed(in_data) * $signed(kern_data);
        tap_term  = d_pad ? '0 : {{(acc_w-2*data_size){prod[2*data_size-1]}}, prod};
        bias_term = (state == DRAIN) ?
                    {{(acc_w-data_size){bias_data[data_size-1]}}, bias_data} : '0;
        acc_sum   = (d_first ? '0 : acc) + tap_term + bias_term;
    end

    // Accumulate while tap data is arriving; hold through WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (d_valid) begin
            acc <= acc_sum;
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == WRITE);
    assign bias_addr = co;
    assign out_data  = acc[data_size-1:0];

endmodule
